// File: rtl/msg_sequencer_if.sv
// Generator / transmit-sink bundle for msg_sequencer.
//   master (sequencer): drives _index, _gen_enable, _tx_data, _tx_valid;
//                       receives _char_in from the generator, _tx_ready from the sink.
//   slave  (generator + sink side): the mirror image.
interface msg_sequencer_if #(
  parameter int IDX_W = 4
);
  logic [IDX_W-1:0] _index;      // generator index, 1..MSG_LEN while active
  logic             _gen_enable; // generator enable, FETCH only
  logic [7:0]       _char_in;    // generator character, combinational from _index
  logic [7:0]       _tx_data;    // registered character to the sink
  logic             _tx_valid;   // _tx_data valid
  logic             _tx_ready;   // sink accepts on _tx_valid && _tx_ready

  modport master (
    output _index, _gen_enable, _tx_data, _tx_valid,
    input  _char_in, _tx_ready
  );

  modport slave (
    input  _index, _gen_enable, _tx_data, _tx_valid,
    output _char_in, _tx_ready
  );
endinterface

// File: rtl/msg_sequencer.sv
// msg_sequencer: walks the fixed-message generator index 1..MSG_LEN, registers
// each character and holds it on a valid/ready sink until accepted. The message
// is sent _repeat times (0 counts as 1) with GAP_CYCLES idle cycles between
// repetitions; an abort stops the sequence at the next character boundary.
// Ports:
//   _clock, _reset : clock, synchronous active-high reset
//   _start         : begin a sequence (IDLE only)
//   _repeat        : message count, latched at start
//   _abort         : early-stop request (busy only, sticky)
//   bus            : generator index/enable/char and tx valid/ready/data
//   _busy          : not IDLE
//   _done          : one-cycle end-of-sequence pulse
//   _aborted       : sequence ended by abort; held until next start
//   _msg_count     : messages fully sent (saturates at 15)
module msg_sequencer #(
  parameter int MSG_LEN    = 12,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic       _clock,
  input  logic       _reset,
  input  logic       _start,
  input  logic [3:0] _repeat,
  input  logic       _abort,
  msg_sequencer_if.master bus,
  output logic       _busy,
  output logic       _done,
  output logic       _aborted,
  output logic [3:0] _msg_count
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [7:0]       data_q, data_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [3:0]       rem_q, rem_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             abort_q, abort_n;
  logic             aborted_q, aborted_n;
  logic             abort_any;

  // A pulse arriving in the very cycle of a decision point counts as well as
  // one latched earlier.
  assign abort_any = abort_q | _abort;

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    data_n    = data_q;
    cnt_n     = cnt_q;
    rem_n     = rem_q;
    gap_n     = gap_q;
    aborted_n = aborted_q;
    abort_n   = abort_q | (_abort && (state != S_IDLE));

    case (state)
      S_IDLE: begin
        if (_start) begin
          rem_n     = (_repeat == 4'd0) ? 4'd1 : _repeat;
          idx_n     = IDX_W'(1);
          cnt_n     = 4'd0;
          aborted_n = 1'b0;
          abort_n   = 1'b0;
          state_n   = S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort_any) begin
          aborted_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          data_n  = bus._char_in;
          state_n = S_SEND;
        end
      end

      // Abort never cuts a character short: it is only acted on after the
      // handshake. The final character of the final message always ends
      // normally, even with an abort pending.
      S_SEND: begin
        if (bus._tx_ready) begin
          if (idx_q != LAST_IDX) begin
            if (abort_any) begin
              aborted_n = 1'b1;
              state_n   = S_DONE;
            end else begin
              idx_n   = idx_q + IDX_W'(1);
              state_n = S_FETCH;
            end
          end else begin
            cnt_n = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
            rem_n = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_n = S_DONE;
            end else if (abort_any) begin
              aborted_n = 1'b1;
              state_n   = S_DONE;
            end else begin
              gap_n   = '0;
              state_n = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (abort_any) begin
          aborted_n = 1'b1;
          state_n   = S_DONE;
        end else if (gap_q == GAP_LAST) begin
          idx_n   = IDX_W'(1);
          state_n = S_FETCH;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end

      S_DONE: begin
        idx_n   = '0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      data_q    <= data_n;
      cnt_q     <= cnt_n;
      rem_q     <= rem_n;
      gap_q     <= gap_n;
      abort_q   <= abort_n;
      aborted_q <= aborted_n;
    end
  end

  assign bus._index      = idx_q;
  assign bus._gen_enable = (state == S_FETCH);
  assign bus._tx_data    = data_q;
  assign bus._tx_valid   = (state == S_SEND);
  assign _busy           = (state != S_IDLE);
  assign _done           = (state == S_DONE);
  assign _aborted        = aborted_q;
  assign _msg_count      = cnt_q;

endmodule

// File: tb/tb_msg_sequencer.sv
module tb_msg_sequencer;
  localparam int MSG_LEN    = 12;
  localparam int IDX_W      = 4;
  localparam int GAP_CYCLES = 3;
  localparam int BOUND      = 800;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort_in;
  logic [3:0] rep_in;
  logic       busy, done, aborted;
  logic [3:0] msg_count;

  msg_sequencer_if #(.IDX_W(IDX_W)) bus();

  msg_sequencer #(
    .MSG_LEN(MSG_LEN), .IDX_W(IDX_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    ._clock(clk), ._reset(rst), ._start(start), ._repeat(rep_in),
    ._abort(abort_in), .bus(bus), ._busy(busy), ._done(done),
    ._aborted(aborted), ._msg_count(msg_count)
  );

  always #5 clk = ~clk;

  // Character generator: "Hello World!" at indices 1..12.
  logic [7:0] rom [0:MSG_LEN-1] = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111, 8'd32,
                                    8'd87, 8'd111, 8'd114, 8'd108, 8'd100, 8'd33};
  always_comb begin
    bus._char_in = 8'h00;
    if (int'(bus._index) >= 1 && int'(bus._index) <= MSG_LEN)
      bus._char_in = rom[int'(bus._index) - 1];
  end

  typedef struct {
    string name;
    int    rep;
    int    pct;        // ready probability in percent; 100 = always ready
    int    stall_lo;   // forced ready-low window (cycles relative to start)
    int    stall_hi;
    int    abort_at;   // cycle of one-cycle abort pulse, -1 none
    int    dup_start;  // cycle of an extra start pulse, -1 none
    int    exp_len;
    int    exp_done;
    int    exp_cnt;
    int    exp_abt;
  } vec_t;

  int checks = 0;
  int failures = 0;
  bit rdy_tab [BOUND];
  logic [7:0] got [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_index"},     int'(bus._index), 0);
    chk({tag, "_gen_en"},    int'(bus._gen_enable), 0);
    chk({tag, "_tx_data"},   int'(bus._tx_data), 0);
    chk({tag, "_tx_valid"},  int'(bus._tx_valid), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_aborted"},   int'(aborted), 0);
    chk({tag, "_msg_count"}, int'(msg_count), 0);
  endtask

  task automatic draw_ready(input vec_t v);
    for (int c = 0; c < BOUND; c++) begin
      if (c >= v.stall_lo && c <= v.stall_hi) rdy_tab[c] = 1'b0;
      else if (v.pct >= 100)                  rdy_tab[c] = 1'b1;
      else rdy_tab[c] = ($urandom_range(0, 99) < v.pct);
    end
  endtask

  // Cycle of _done for an unaborted run: each character needs a fetch cycle
  // and then waits in send until ready; messages are separated by the gap.
  function automatic int model_done(input int nmsg);
    int t = 0;
    for (int m = 0; m < nmsg; m++) begin
      if (m > 0) t += GAP_CYCLES;
      for (int k = 0; k < MSG_LEN; k++) begin
        t += 2;
        while (t < BOUND - 1 && !rdy_tab[t]) t++;
      end
    end
    return t + 1;
  endfunction

  task automatic run_seq(input vec_t v);
    int first_v = -1, done_c = -1, ndone = 0, stab = 0, bsy = 0, extra = 0;
    int busy_after = -1, idx_after = -1, bad_bytes = 0;
    int dab = -1, dcnt = -1;
    logic phold = 1'b0;
    logic [7:0] pdata = 8'h00;
    got.delete();
    @(posedge clk); #1;
    rep_in = 4'(v.rep);
    for (int c = 0; c < BOUND; c++) begin
      start = (c == 0) || (c == v.dup_start);
      abort_in = (c == v.abort_at);
      bus._tx_ready = rdy_tab[c];
      @(negedge clk);
      if (c >= 1 && done_c < 0 && !busy) bsy++;
      if (phold && (!bus._tx_valid || bus._tx_data !== pdata)) stab++;
      if (bus._tx_valid) begin
        if (first_v < 0) first_v = c;
        if (bus._tx_ready) got.push_back(bus._tx_data);
      end
      phold = bus._tx_valid && !bus._tx_ready;
      pdata = bus._tx_data;
      if (done) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c; dab = int'(aborted); dcnt = int'(msg_count);
        end
      end
      if (done_c >= 0 && c == done_c + 1) begin
        busy_after = int'(busy); idx_after = int'(bus._index);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort_in = 1'b0; bus._tx_ready = 1'b1;
    chk({v.name, "_done_seen"}, int'(done_c >= 0), 1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk({v.name, "_done_cycle"}, done_c, v.exp_done);
    chk({v.name, "_done_pulses"}, ndone, 1);
    chk({v.name, "_byte_count"}, got.size(), v.exp_len);
    for (int k = 0; k < got.size() && k < v.exp_len; k++)
      if (got[k] !== rom[k % MSG_LEN]) bad_bytes++;
    chk({v.name, "_byte_errs"}, bad_bytes, 0);
    chk({v.name, "_msg_count"}, dcnt, v.exp_cnt);
    chk({v.name, "_aborted"}, dab, v.exp_abt);
    chk({v.name, "_hold_stable"}, stab, 0);
    chk({v.name, "_busy_gap"}, bsy, 0);
    chk({v.name, "_busy_after"}, busy_after, 0);
    chk({v.name, "_index_after"}, idx_after, 0);
    chk({v.name, "_idle_after"}, extra, 0);
    if (v.exp_len > 0) chk({v.name, "_first_valid"}, first_v, 2);
  endtask

  vec_t tab [8];

  initial begin
    vec_t v;
    tab[0] = '{"single",      1, 100, -1, -1, -1, -1, 12, 25, 1, 0};
    tab[1] = '{"repeat2",     2, 100, -1, -1, -1, -1, 24, 52, 2, 0};
    tab[2] = '{"repeat0_dup", 0, 100, -1, -1, -1,  6, 12, 25, 1, 0};
    tab[3] = '{"repeat3",     3, 100, -1, -1, -1, -1, 36, 79, 3, 0};
    tab[4] = '{"abort_W",     1, 100, 14, 17, 15, -1,  7, 19, 0, 1};
    tab[5] = '{"abort_gap",   2, 100, -1, -1, 26, -1, 12, 27, 1, 1};
    tab[6] = '{"abort_last",  1, 100, -1, -1, 24, -1, 12, 25, 1, 0};
    tab[7] = '{"abort_fetch", 1, 100, -1, -1,  3, -1,  1,  4, 0, 1};

    rst = 1'b1; start = 1'b0; abort_in = 1'b0; rep_in = 4'd0;
    bus._tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("por");

    for (int i = 0; i < 8; i++) begin
      draw_ready(tab[i]);
      run_seq(tab[i]);
    end

    // Randomised backpressure and repeat count against the timing model.
    for (int i = 0; i < 5; i++) begin
      int n;
      v = '{"rand", 0, 0, -1, -1, -1, -1, 0, 0, 0, 0};
      v.rep = int'($urandom_range(0, 4));
      v.pct = int'($urandom_range(20, 90));
      n = (v.rep == 0) ? 1 : v.rep;
      draw_ready(v);
      v.exp_len = n * MSG_LEN;
      v.exp_cnt = n;
      v.exp_done = model_done(n);
      run_seq(v);
    end

    // Reset while index 5 is being sent, then a clean full message.
    @(posedge clk); #1;
    start = 1'b1; rep_in = 4'd1; bus._tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_valid", int'(bus._tx_valid), 1);
    chk("rst_mid_index", int'(bus._index), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    draw_ready(tab[0]);
    v = tab[0];
    v.name = "after_reset";
    run_seq(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msg_sequencer.md
# msg_sequencer

Transmit controller that sequences the fixed-message character generator (the 12-entry "Hello World!" letter source indexed 1..12) onto a byte-wide valid/ready sink such as a UART transmitter. On a start pulse it walks the generator index from 1 to MSG_LEN, registers each returned character, and holds it on the sink interface until accepted. It repeats the message a programmable number of times with a fixed idle gap between repetitions. It sits between the top-level control logic and the generator/transmitter pair, replacing the generator's free-running counter.

## Interface
Parameters:
- MSG_LEN, 12: characters per message; generator indices 1..MSG_LEN.
- IDX_W, 4: generator index width; MSG_LEN ≤ 2^IDX_W−1.
- GAP_CYCLES, 3: idle cycles between repetitions; must be ≥1.

Ports:
- _clock  in  1  sole clock; all logic on its rising edge.
- _reset  in  1  synchronous, active-high reset.
- _start  in  1  begin sequence; sampled only in IDLE.
- _repeat  in  4  message count, latched at start; 0 treated as 1.
- _abort  in  1  request early stop; sampled only while busy.
- _char_in  in  8  character from generator (combinational from _index).
- _index  out  IDX_W  generator index, registered.
- _gen_enable  out  1  generator enable; high only in FETCH.
- _tx_data  out  8  registered character to sink.
- _tx_valid  out  1  character on _tx_data is valid.
- _tx_ready  in  1  sink accepts when _tx_valid && _tx_ready.
- _busy  out  1  high in every state except IDLE.
- _done  out  1  one-cycle pulse at sequence end.
- _aborted  out  1  with _done: sequence ended by abort; holds until next start.
- _msg_count  out  4  messages fully sent in current/last sequence.

## Operation
- States: IDLE, FETCH, SEND, GAP, DONE.
- IDLE: _start → latch _repeat (0→1) into remaining count, _index←1, clear _msg_count and _aborted, go FETCH.
- FETCH (1 cycle): _gen_enable=1; _tx_data←_char_in; go SEND.
- SEND: _tx_valid=1, _tx_data stable. On handshake:
  - _index<MSG_LEN: _index←_index+1, go FETCH.
  - _index==MSG_LEN: _msg_count+1 (saturating at 15); remaining−1; remaining now 0 → DONE, else → GAP.
- GAP: count GAP_CYCLES cycles, then _index←1, go FETCH.
- DONE (1 cycle): _done=1, go IDLE; _index←0.
- Abort: latched in a sticky flag whenever busy. Never interrupts SEND; _tx_valid never drops before handshake. At the next FETCH or GAP entry, or immediately in GAP/FETCH, go DONE with _aborted=1. Abort coinciding with the last character's handshake ends normally, _aborted=0.
- _start while busy: ignored. _abort in IDLE: ignored.
- _index arithmetic: IDX_W bits, never wraps (max MSG_LEN).

## Timing
- Reset values: _index=0, _gen_enable=0, _tx_data=0, _tx_valid=0, _busy=0, _done=0, _aborted=0, _msg_count=0, state IDLE, abort flag clear.
- Reset mid-sequence: all of the above at the next edge, regardless of state; in-flight character dropped.
- Start→first _tx_valid: 2 cycles (start at cycle 0, FETCH cycle 1, SEND cycle 2).
- With _tx_ready held high: one character per 2 cycles; character k valid in cycle 2k.
- Last handshake→_done: 1 cycle. _busy high from cycle after start through DONE cycle inclusive.
- Inter-message: last handshake at cycle t → GAP cycles t+1..t+GAP_CYCLES, FETCH t+GAP_CYCLES+1.
- Backpressure: each cycle of _tx_ready low during SEND extends timing by one cycle; nothing else changes.

## Test plan
- Single message, _repeat=1, _tx_ready=1, start at cycle 0 → bytes 72,101,108,108,111,32,87,111,114,108,100,33 valid at cycles 2,4..24; _done at 25; _msg_count=1; _busy low at 26.
- _repeat=2, GAP_CYCLES=3, ready=1 → second message 'H' valid at cycle 29, final '!' at 51, _done at 52, _msg_count=2.
- Random _tx_ready backpressure → _tx_data stable while _tx_valid && !_tx_ready; byte stream identical to scenario 1; no dropped/duplicated bytes.
- _abort pulse while 'W' (index 7) held with ready=0 → 'W' stays valid until ready; then no further bytes; _done next cycle with _aborted=1, _msg_count=0.
- _reset asserted during SEND of index 5 → next cycle all outputs at reset values; subsequent _start produces full message from 'H'.
- _repeat=0 → exactly one message; _start pulsed during busy → ignored, single _done.
